irq_pending_latch: RTL and testbench

//  Upstream stage of the 4-to-2 priority encoder: synchronises 4 async request lines,

---
 rtl/irq_pending_latch.sv | 85 ++++++++
 tb/tb_irq_pending_latch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Synchronises four async request lines, latches their rising edges as sticky pending bits
// until acknowledged, and flags unmasked pending requests on irq. Optional IRQ_PEND_OVF_EN adds overflow.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    output logic [3:0] pending,
    output logic       irq
`ifdef IRQ_PEND_OVF_EN
    ,
    output logic [3:0] overflow
`endif
);

    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_hist;
    logic [3:0] r_pending;
    logic       r_irq;

    logic [3:0] w_rise;
    logic [3:0] w_ack_vec;
    logic [3:0] w_pend_nx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= req_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

    // NOTE: default first so the conditional write cannot infer a latch.
    always_comb begin
        w_ack_vec = '0;
        if (ack) begin
            w_ack_vec[ack_idx] = 1'b1;
        end
    end

    // A new edge beats a same-cycle ack on that line.
    assign w_pend_nx = w_rise | (r_pending & ~w_ack_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pend_nx;
            r_irq     <= |(w_pend_nx & ~mask);
        end
    end

    assign pending = r_pending;
    assign irq     = r_irq;

`ifdef IRQ_PEND_OVF_EN
    logic [3:0] r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | (w_rise & r_pending);
        end
    end

    assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: table-driven vectors plus hand sequences,
// expectations queued on drive and compared after the clock edge.
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic [3:0] pending;
    logic       irq;
`ifdef IRQ_PEND_OVF_EN
    logic [3:0] overflow;
`endif

    irq_pending_latch #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .mask     (mask),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .pending  (pending),
        .irq      (irq)
`ifdef IRQ_PEND_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] mask;
        logic       ack;
        logic [1:0] idx;
        logic [3:0] exp_pend;
        logic       exp_irq;
        logic [3:0] exp_ovf;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] pend;
        logic       irq;
        logic [3:0] ovf;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_total  = 0;
    int   n_passed = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] m,
                                input logic a, input logic [1:0] ix, input logic [3:0] ep,
                                input logic ei, input logic [3:0] eo, input string nm);
        vec_t v;
        v.rst = r; v.req = rq; v.mask = m; v.ack = a; v.idx = ix;
        v.exp_pend = ep; v.exp_irq = ei; v.exp_ovf = eo; v.name = nm;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        rst = v.rst; req_in = v.req; mask = v.mask; ack = v.ack; ack_idx = v.idx;
        e.pend = v.exp_pend; e.irq = v.exp_irq; e.ovf = v.exp_ovf; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            got = sb.pop_front();
            check({got.name, "_pending"}, pending, got.pend);
            check({got.name, "_irq"}, {3'b000, irq}, {3'b000, got.irq});
`ifdef IRQ_PEND_OVF_EN
            check({got.name, "_overflow"}, overflow, got.ovf);
`endif
        end
    endtask

    task automatic hand(input logic r, input logic [3:0] rq, input logic [3:0] m,
                        input logic a, input logic [1:0] ix, input logic [3:0] ep,
                        input logic ei, input logic [3:0] eo, input string nm);
        vec_t v;
        v.rst = r; v.req = rq; v.mask = m; v.ack = a; v.idx = ix;
        v.exp_pend = ep; v.exp_irq = ei; v.exp_ovf = eo; v.name = nm;
        step(v);
    endtask

    initial begin
        rst = 1'b1; req_in = '0; mask = '0; ack = 1'b0; ack_idx = '0;

        // Reset held two cycles with all lines high, then all four latch at the third edge.
        add(1, 4'b1111, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "rst_a");
        add(1, 4'b1111, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "rst_b");
        add(0, 4'b1111, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "rel_e1");
        add(0, 4'b1111, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "rel_e2");
        add(0, 4'b1111, 4'b0000, 0, 2'd0, 4'b1111, 1, 4'b0000, "rel_e3");
        // Ack one line per cycle while levels stay high: no re-pend.
        add(0, 4'b1111, 4'b0000, 1, 2'd0, 4'b1110, 1, 4'b0000, "ack0");
        add(0, 4'b1111, 4'b0000, 1, 2'd1, 4'b1100, 1, 4'b0000, "ack1");
        add(0, 4'b1111, 4'b0000, 1, 2'd2, 4'b1000, 1, 4'b0000, "ack2");
        add(0, 4'b1111, 4'b0000, 1, 2'd3, 4'b0000, 0, 4'b0000, "ack3");
        for (int i = 0; i < 4; i++)
            add(0, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "drain");
        // Single line 2 rise: exactly three edges.
        add(0, 4'b0100, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "l2_e1");
        add(0, 4'b0100, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "l2_e2");
        add(0, 4'b0100, 4'b0000, 0, 2'd0, 4'b0100, 1, 4'b0000, "l2_e3");
        add(0, 4'b0100, 4'b0000, 1, 2'd2, 4'b0000, 0, 4'b0000, "l2_ack");
        // pending=1010, ack 3 then 1.
        add(0, 4'b1010, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "p1010_e1");
        add(0, 4'b1010, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "p1010_e2");
        add(0, 4'b1010, 4'b0000, 0, 2'd0, 4'b1010, 1, 4'b0000, "p1010_e3");
        add(0, 4'b1010, 4'b0000, 1, 2'd3, 4'b0010, 1, 4'b0000, "p1010_ack3");
        add(0, 4'b1010, 4'b0000, 1, 2'd1, 4'b0000, 0, 4'b0000, "p1010_ack1");
        add(0, 4'b1010, 4'b0000, 1, 2'd0, 4'b0000, 0, 4'b0000, "ack_idle");
        for (int i = 0; i < 3; i++)
            add(0, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "drain2");
        // Masked line 1: pends without irq, unmask raises irq next edge.
        add(0, 4'b0010, 4'b1111, 0, 2'd0, 4'b0000, 0, 4'b0000, "msk_e1");
        add(0, 4'b0010, 4'b1111, 0, 2'd0, 4'b0000, 0, 4'b0000, "msk_e2");
        add(0, 4'b0010, 4'b1111, 0, 2'd0, 4'b0010, 0, 4'b0000, "msk_e3");
        add(0, 4'b0010, 4'b0000, 0, 2'd0, 4'b0010, 1, 4'b0000, "unmask");
        add(0, 4'b0010, 4'b1111, 0, 2'd0, 4'b0010, 0, 4'b0000, "remask");
        add(0, 4'b0010, 4'b0000, 1, 2'd1, 4'b0000, 0, 4'b0000, "msk_ack");

        foreach (vecs[i]) step(vecs[i]);

        // Level held after ack does not re-pend; drop one cycle and raise re-pends.
        hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "lvl_e1");
        hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "lvl_e2");
        hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b1000, 1, 4'b0000, "lvl_e3");
        hand(0, 4'b1000, 4'b0000, 1, 2'd3, 4'b0000, 0, 4'b0000, "lvl_ack");
        for (int i = 0; i < 3; i++)
            hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "lvl_held");
        hand(0, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "lvl_drop");
        hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "lvl_r1");
        hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "lvl_r2");
        hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b1000, 1, 4'b0000, "lvl_r3");
        hand(0, 4'b1000, 4'b0000, 1, 2'd3, 4'b0000, 0, 4'b0000, "lvl_ack2");

        // New rise on line 0 coinciding with ack of line 0: set wins, overflow flagged.
        hand(0, 4'b1001, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "ov_e1");
        hand(0, 4'b1001, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "ov_e2");
        hand(0, 4'b1001, 4'b0000, 0, 2'd0, 4'b0001, 1, 4'b0000, "ov_e3");
        hand(0, 4'b1000, 4'b0000, 0, 2'd0, 4'b0001, 1, 4'b0000, "ov_drop");
        hand(0, 4'b1001, 4'b0000, 0, 2'd0, 4'b0001, 1, 4'b0000, "ov_r1");
        hand(0, 4'b1001, 4'b0000, 0, 2'd0, 4'b0001, 1, 4'b0000, "ov_r2");
        hand(0, 4'b1001, 4'b0000, 1, 2'd0, 4'b0001, 1, 4'b0001, "ov_set_wins");
        hand(0, 4'b1001, 4'b0000, 1, 2'd0, 4'b0000, 0, 4'b0001, "ov_clear");

        // Reset mid-operation with lines held high: cleared, then seen as fresh edges.
        hand(1, 4'b1001, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "mid_rst");
        hand(0, 4'b1001, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "post_e1");
        hand(0, 4'b1001, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, "post_e2");
        hand(0, 4'b1001, 4'b0100, 0, 2'd0, 4'b1001, 1, 4'b0000, "post_e3");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
